line_buff_cntrl: RTL and testbench
==================================

LINE_BUFF_CNTRL -- requirements
Module: line_buff_cntrl

Interface
REQ-001 The block SHALL expose the following parameters:
  - HEIGHT_PX, default 480, active frame lines.
  - TILE_HEIGHT, default 4, display lines per tile row; power of two.
  - TILE_ROWS, default HEIGHT_PX/TILE_HEIGHT (120), tile rows per frame.
  - ROW_CTR_WIDTH, default $clog2(TILE_ROWS), tile row counter width.
REQ-002 The block SHALL have the following ports (one clock; reset is asynchronous and active-low):
  - clk_i  in  1  clock.
  - rstn_i  in  1  asynchronous active-low reset.
  - frame_start_i  in  1  one-cycle pulse, start of vertical blank preceding a frame.
  - line_end_i  in  1  one-cycle pulse, end of each active display line.
  - buff_fill_done_i  in  2  per-buffer one-cycle fill-complete pulse.
  - buff_fill_req_o  out  2  per-buffer fill request, level, at most one bit set.
  - buff_sel_o  out  2  one-hot display buffer select; 00 = none.
  - tile_row_o  out  ROW_CTR_WIDTH  tile row currently displayed.
  - underrun_o  out  1  sticky: swap to an unfilled buffer.
  - frame_err_o  out  1  sticky: frame_start_i during an incomplete frame.
  - underrun_cnt_o  out  16  underrun count (see Configuration).

Function
REQ-003 States SHALL be IDLE, PREFILL_0, PREFILL_1 and DISPLAY.
REQ-004 IDLE SHALL go to PREFILL_0 on frame_start_i, asserting buff_fill_req_o=01 on the next cycle.
REQ-005 PREFILL_0 SHALL hold req=01 until buff_fill_done_i[0], then on that edge set req=10 and enter PREFILL_1.
REQ-006 PREFILL_1 SHALL hold req=10 until buff_fill_done_i[1], then set req=00, buff_sel_o=01, tile_row_o=0, line counter=0, and enter DISPLAY.
REQ-007 The per-buffer valid flag SHALL be set on buff_fill_done_i[n] and cleared when buffer n is deselected for refill.
REQ-008 In DISPLAY, each line_end_i SHALL increment the line counter (width log2(TILE_HEIGHT)).
REQ-009 A line_end_i with line counter = TILE_HEIGHT-1 and tile_row_o < TILE_ROWS-1 SHALL, on the same edge:
  - wrap the line counter to 0;
  - increment tile_row_o;
  - swap buff_sel_o to the other buffer;
  - clear the valid flag of the released buffer.
REQ-010 The released buffer SHALL receive a fill request on the same edge as the swap only if (new tile_row_o + 1) < TILE_ROWS, giving exactly TILE_ROWS fills per frame.
REQ-011 A swap to a buffer whose valid flag is 0 SHALL set underrun_o; the swap SHALL still occur.
REQ-012 A line_end_i with line counter = TILE_HEIGHT-1 and tile_row_o = TILE_ROWS-1 SHALL set buff_sel_o=00, reset both counters and enter IDLE.
REQ-013 An asserted request SHALL remain high until its done pulse, deasserting on the done edge; a new request SHALL NOT be issued while another is outstanding.
REQ-014 If a swap requires a fill while the other fill is still outstanding, the request SHALL be queued and issued on the cycle after the outstanding done.
REQ-015 A done pulse for a buffer with no outstanding request SHALL be ignored.
REQ-016 line_end_i outside DISPLAY SHALL be ignored.
REQ-017 frame_start_i outside IDLE SHALL set frame_err_o and be otherwise ignored; the current frame completes.
REQ-018 Simultaneous frame_start_i and a final line_end_i (REQ-012) SHALL enter IDLE, with no error and no restart.

Reset
REQ-019 While rstn_i=0, asynchronously:
  - state=IDLE;
  - buff_fill_req_o=00, buff_sel_o=00, tile_row_o=0;
  - line counter=0, valid flags=00, queued request cleared;
  - underrun_o=0, frame_err_o=0, underrun_cnt_o=0.
REQ-020 Reset mid-fill SHALL abandon the fill; a done pulse arriving after reset release SHALL be ignored per REQ-015.

Configuration
REQ-021 With LINE_BUFF_CNTRL_STATS_EN defined, underrun_cnt_o SHALL increment by one per underrun event, saturating at 16'hFFFF.
REQ-022 Without LINE_BUFF_CNTRL_STATS_EN, underrun_cnt_o SHALL be tied to 0 and no counter SHALL be synthesised; underrun_o is unaffected.

Verification
REQ-023 The bench SHALL cover the following scenarios:
  - Reset, then frame_start_i with done returned 3 cycles after each request -> req 01 then 10; sel=01 and tile_row_o=0 after the second done.
  - 4 line_end_i in DISPLAY -> on the 4th: sel=10, req=01, tile_row_o=1.
  - Full frame with prompt dones -> exactly 120 fill requests, tile_row_o reaches 119, sel=00 after 480 line_end_i, state IDLE.
  - Done withheld for buffer 0 past the next swap -> underrun_o=1; underrun_cnt_o=1 with the macro, 0 without.
  - frame_start_i at tile_row_o=50 -> frame_err_o=1 and no new request; frame completes normally.
  - rstn_i low while req=10 pending, then a stray done[1] -> all outputs 0 and state stays IDLE.

Source files
------------

// File: rtl/line_buff_cntrl.sv
// Ping-pong tile line buffer controller: prefetches two buffers, then swaps every TILE_HEIGHT lines.
// Optional underrun statistics counter enabled by defining LINE_BUFF_CNTRL_STATS_EN.
module line_buff_cntrl #(
    parameter int HEIGHT_PX     = 480,
    parameter int TILE_HEIGHT   = 4,
    parameter int TILE_ROWS     = HEIGHT_PX / TILE_HEIGHT,
    parameter int ROW_CTR_WIDTH = $clog2(TILE_ROWS)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     frame_start_i,
    input  logic                     line_end_i,
    input  logic [1:0]               buff_fill_done_i,
    output logic [1:0]               buff_fill_req_o,
    output logic [1:0]               buff_sel_o,
    output logic [ROW_CTR_WIDTH-1:0] tile_row_o,
    output logic                     underrun_o,
    output logic                     frame_err_o,
    output logic [15:0]              underrun_cnt_o
);

    localparam int LINE_W = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
    localparam logic [LINE_W-1:0]        LAST_LINE = LINE_W'(TILE_HEIGHT - 1);
    localparam logic [ROW_CTR_WIDTH-1:0] LAST_ROW  = ROW_CTR_WIDTH'(TILE_ROWS - 1);

    typedef enum logic [1:0] {IDLE, PREFILL_0, PREFILL_1, DISPLAY} state_t;

    state_t            state;
    logic [LINE_W-1:0] line_cnt;
    logic [1:0]        valid;
    logic [1:0]        queued;

    logic [1:0] acked, req_keep, valid_eff, sel_swapped, req_nxt, queued_nxt;
    logic       last_line, swap, frame_end, need_fill, underrun_evt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acked        = buff_fill_req_o & buff_fill_done_i;
        req_keep     = buff_fill_req_o & ~buff_fill_done_i;
        valid_eff    = valid | acked;
        sel_swapped  = {buff_sel_o[0], buff_sel_o[1]};
        last_line    = (state == DISPLAY) && line_end_i && (line_cnt == LAST_LINE);
        swap         = last_line && (tile_row_o != LAST_ROW);
        frame_end    = last_line && (tile_row_o == LAST_ROW);
        need_fill    = swap && ((int'(tile_row_o) + 2) < TILE_ROWS);
        underrun_evt = swap && ~|(valid_eff & sel_swapped);
        req_nxt      = req_keep;
        queued_nxt   = queued;
        if (state == IDLE && frame_start_i) begin
            req_nxt = 2'b01;
        end else if (state == PREFILL_0 && acked[0]) begin
            req_nxt = 2'b10;
        end else if (need_fill) begin
            // Only one fill may be outstanding; a second one waits for the first done.
            if (req_keep == 2'b00) req_nxt    = buff_sel_o;
            else                   queued_nxt = buff_sel_o;
        end else if (queued != 2'b00 && req_keep == 2'b00) begin
            req_nxt    = queued;
            queued_nxt = 2'b00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            buff_fill_req_o <= 2'b00;
            buff_sel_o      <= 2'b00;
            tile_row_o      <= '0;
            line_cnt        <= '0;
            valid           <= 2'b00;
            queued          <= 2'b00;
            underrun_o      <= 1'b0;
            frame_err_o     <= 1'b0;
        end else begin
            buff_fill_req_o <= req_nxt;
            queued          <= queued_nxt;
            valid           <= valid_eff;
            case (state)
                IDLE: begin
                    if (frame_start_i) state <= PREFILL_0;
                end
                PREFILL_0: begin
                    if (frame_start_i) frame_err_o <= 1'b1;
                    if (acked[0])      state       <= PREFILL_1;
                end
                PREFILL_1: begin
                    if (frame_start_i) frame_err_o <= 1'b1;
                    if (acked[1]) begin
                        state      <= DISPLAY;
                        buff_sel_o <= 2'b01;
                        tile_row_o <= '0;
                        line_cnt   <= '0;
                    end
                end
                DISPLAY: begin
                    if (frame_start_i && !frame_end) frame_err_o <= 1'b1;
                    if (line_end_i) line_cnt <= (line_cnt == LAST_LINE) ? '0 : line_cnt + LINE_W'(1);
                    if (swap) begin
                        buff_sel_o <= sel_swapped;
                        tile_row_o <= tile_row_o + ROW_CTR_WIDTH'(1);
                        valid      <= valid_eff & ~buff_sel_o;
                        if (underrun_evt) underrun_o <= 1'b1;
                    end
                    if (frame_end) begin
                        state      <= IDLE;
                        buff_sel_o <= 2'b00;
                        tile_row_o <= '0;
                        line_cnt   <= '0;
                        valid      <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_BUFF_CNTRL_STATS_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                                 underrun_cnt_o <= 16'h0000;
        else if (underrun_evt && underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 16'h0001;
    end
`else
    assign underrun_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_line_buff_cntrl.sv
// Self-checking bench for line_buff_cntrl: directed vector table, corner sequences and
// randomized frames compared against a frame-level reference model.
module tb_line_buff_cntrl;

    localparam int HEIGHT_PX = 480;
    localparam int TH        = 4;
    localparam int ROWS      = 120;
    localparam int RW        = 7;
`ifdef LINE_BUFF_CNTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b1;
    logic          frame_start_i = 1'b0;
    logic          line_end_i = 1'b0;
    logic [1:0]    buff_fill_done_i = 2'b00;
    logic [1:0]    buff_fill_req_o, buff_sel_o;
    logic [RW-1:0] tile_row_o;
    logic          underrun_o, frame_err_o;
    logic [15:0]   underrun_cnt_o;

    line_buff_cntrl dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .frame_start_i(frame_start_i), .line_end_i(line_end_i),
        .buff_fill_done_i(buff_fill_done_i), .buff_fill_req_o(buff_fill_req_o),
        .buff_sel_o(buff_sel_o), .tile_row_o(tile_row_o), .underrun_o(underrun_o),
        .frame_err_o(frame_err_o), .underrun_cnt_o(underrun_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: frame progress as a count of displayed lines, fills as a FIFO of buffer ids.
    typedef enum int {M_IDLE, M_PF0, M_PF1, M_DISP} mphase_t;
    mphase_t m_phase;
    int      m_lines;
    int      m_fills[$];
    bit      m_valid[2];
    bit      m_under, m_ferr;
    int      m_ucnt;

    int         g_fills, g_max_row;
    logic [1:0] prev_req;

    task automatic model_reset();
        m_phase = M_IDLE; m_lines = 0; m_fills.delete();
        m_valid[0] = 0; m_valid[1] = 0; m_under = 0; m_ferr = 0; m_ucnt = 0;
    endtask

    task automatic model_step(input bit fs, input bit le, input bit [1:0] dn);
        int done_buf, t, tgt, rel;
        bit last;
        done_buf = -1; last = 0;
        if (m_fills.size() > 0 && dn[m_fills[0]]) begin
            done_buf = m_fills[0];
            m_valid[done_buf] = 1;
            void'(m_fills.pop_front());
        end
        case (m_phase)
            M_IDLE: if (fs) begin m_fills.push_back(0); m_phase = M_PF0; end
            M_PF0: begin
                if (fs) m_ferr = 1;
                if (done_buf == 0) begin m_fills.push_back(1); m_phase = M_PF1; end
            end
            M_PF1: begin
                if (fs) m_ferr = 1;
                if (done_buf == 1) begin m_phase = M_DISP; m_lines = 0; end
            end
            M_DISP: begin
                if (le) begin
                    m_lines++;
                    if (m_lines == HEIGHT_PX) begin
                        last = 1; m_phase = M_IDLE; m_lines = 0;
                        m_valid[0] = 0; m_valid[1] = 0;
                    end else if (m_lines % TH == 0) begin
                        t = m_lines / TH; tgt = t % 2; rel = 1 - tgt;
                        if (!m_valid[tgt]) begin
                            m_under = 1;
                            if (STATS && m_ucnt < 65535) m_ucnt++;
                        end
                        m_valid[rel] = 0;
                        if (t + 1 < ROWS) m_fills.push_back(rel);
                    end
                end
                if (fs && !last) m_ferr = 1;
            end
            default: ;
        endcase
    endtask

    function automatic logic [1:0] exp_req();
        if (m_fills.size() == 0) return 2'b00;
        return (m_fills[0] == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] exp_sel();
        if (m_phase != M_DISP) return 2'b00;
        return ((m_lines / TH) % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int exp_row();
        return (m_phase == M_DISP) ? m_lines / TH : 0;
    endfunction

    task automatic compare_model();
        check("model_req", buff_fill_req_o, exp_req());
        check("model_sel", buff_sel_o, exp_sel());
        check("model_row", tile_row_o, exp_row());
        check("model_underrun", underrun_o, m_under);
        check("model_frame_err", frame_err_o, m_ferr);
        check("model_underrun_cnt", underrun_cnt_o, m_ucnt);
    endtask

    task automatic cycle(input bit fs, input bit le, input bit [1:0] dn);
        frame_start_i = fs; line_end_i = le; buff_fill_done_i = dn;
        @(posedge clk_i);
        model_step(fs, le, dn);
        #1;
        frame_start_i = 1'b0; line_end_i = 1'b0; buff_fill_done_i = 2'b00;
        compare_model();
        g_fills += $countones(buff_fill_req_o & ~prev_req);
        prev_req = buff_fill_req_o;
        if (int'(tile_row_o) > g_max_row) g_max_row = int'(tile_row_o);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, buff_fill_req_o, 0);
        check({tag, "_sel"}, buff_sel_o, 0);
        check({tag, "_row"}, tile_row_o, 0);
        check({tag, "_underrun"}, underrun_o, 0);
        check({tag, "_frame_err"}, frame_err_o, 0);
        check({tag, "_underrun_cnt"}, underrun_cnt_o, 0);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        #2;
        model_reset();
        check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i   = 1'b1;
        prev_req = 2'b00;
    endtask

    // Runs one frame from IDLE; dones answer each request after a random latency.
    task automatic run_frame(input int gap_min, input int gap_max, input int dly_min, input int dly_max,
                             input int err_row, input bit fs_last, input bit noise);
        int gap, dly, age, budget;
        logic [1:0] age_req, dn;
        bit fs, le, err_done, err_now;
        g_fills = 0; g_max_row = 0; err_done = 0;
        cycle(1'b1, 1'b0, 2'b00);
        gap = $urandom_range(gap_max, gap_min);
        dly = $urandom_range(dly_max, dly_min);
        age = 0; age_req = 2'b00;
        for (budget = 0; budget < 20000; budget++) begin
            if (m_phase == M_IDLE) break;
            fs = 0; le = 0; dn = 2'b00; err_now = 0;
            if (buff_fill_req_o != 2'b00) begin
                if (buff_fill_req_o == age_req) age++;
                else begin age = 1; age_req = buff_fill_req_o; end
                if (age >= dly) begin
                    dn = buff_fill_req_o; dly = $urandom_range(dly_max, dly_min);
                    age = 0; age_req = 2'b00;
                end
            end else begin
                age_req = 2'b00;
            end
            if (err_row >= 0 && !err_done && m_phase == M_DISP && m_lines / TH == err_row
                && buff_fill_req_o == 2'b00 && dn == 2'b00) begin
                fs = 1; err_now = 1; err_done = 1;
            end else if (m_phase == M_DISP) begin
                if (gap == 0) begin le = 1; gap = $urandom_range(gap_max, gap_min); end
                else gap--;
            end
            if (fs_last && le && m_lines == HEIGHT_PX - 1) fs = 1;
            if (noise) begin
                if ($urandom_range(63, 0) == 0) fs = 1;
                if (m_phase != M_DISP && $urandom_range(31, 0) == 0) le = 1;
                if ($urandom_range(31, 0) == 0) dn = dn | (~buff_fill_req_o & 2'($urandom_range(3, 1)));
            end
            cycle(fs, le, dn);
            if (err_now) begin
                check("err_flag_set", frame_err_o, 1);
                check("err_no_new_req", buff_fill_req_o, 0);
            end
        end
        check("frame_completed_in_budget", (m_phase == M_IDLE), 1);
    endtask

    typedef struct {
        bit         fs;
        bit         le;
        bit [1:0]   done;
        logic [1:0] req;
        logic [1:0] sel;
        int         row;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 0, 2'b00, 2'b01, 2'b00, 0};
        tbl[1]  = '{0, 0, 2'b00, 2'b01, 2'b00, 0};
        tbl[2]  = '{0, 0, 2'b00, 2'b01, 2'b00, 0};
        tbl[3]  = '{0, 0, 2'b01, 2'b10, 2'b00, 0};
        tbl[4]  = '{0, 0, 2'b00, 2'b10, 2'b00, 0};
        tbl[5]  = '{0, 0, 2'b00, 2'b10, 2'b00, 0};
        tbl[6]  = '{0, 0, 2'b10, 2'b00, 2'b01, 0};
        tbl[7]  = '{0, 1, 2'b00, 2'b00, 2'b01, 0};
        tbl[8]  = '{0, 1, 2'b00, 2'b00, 2'b01, 0};
        tbl[9]  = '{0, 1, 2'b00, 2'b00, 2'b01, 0};
        tbl[10] = '{0, 1, 2'b00, 2'b01, 2'b10, 1};
        tbl[11] = '{0, 0, 2'b01, 2'b00, 2'b10, 1};

        prev_req = 2'b00;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].fs, tbl[i].le, tbl[i].done);
            check($sformatf("tbl%0d_req", i), buff_fill_req_o, tbl[i].req);
            check($sformatf("tbl%0d_sel", i), buff_sel_o, tbl[i].sel);
            check($sformatf("tbl%0d_row", i), tile_row_o, tbl[i].row);
        end

        // Full frame, prompt dones, frame_start coincident with the final line_end.
        do_reset();
        run_frame(3, 3, 2, 2, -1, 1'b1, 1'b0);
        check("frame_fill_count", g_fills, ROWS);
        check("frame_max_row", g_max_row, ROWS - 1);
        check("frame_end_sel", buff_sel_o, 0);
        check("frame_end_req", buff_fill_req_o, 0);
        check("frame_end_no_err", frame_err_o, 0);
        check("frame_end_no_underrun", underrun_o, 0);
        cycle(1'b1, 1'b0, 2'b00);
        check("restart_from_idle_req", buff_fill_req_o, 2'b01);
        check("restart_from_idle_err", frame_err_o, 0);

        // Done for buffer 0 withheld across the next swap: underrun plus a queued request.
        do_reset();
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b01);
        cycle(1'b0, 1'b0, 2'b10);
        repeat (4) cycle(1'b0, 1'b1, 2'b00);
        check("ur_first_swap_req", buff_fill_req_o, 2'b01);
        check("ur_before_flag", underrun_o, 0);
        repeat (4) cycle(1'b0, 1'b1, 2'b00);
        check("ur_flag", underrun_o, 1);
        check("ur_count", underrun_cnt_o, STATS ? 1 : 0);
        check("ur_swap_sel", buff_sel_o, 2'b01);
        check("ur_swap_row", tile_row_o, 2);
        check("ur_queued_not_issued", buff_fill_req_o, 2'b01);
        cycle(1'b0, 1'b0, 2'b01);
        check("ur_queued_issued", buff_fill_req_o, 2'b10);

        // frame_start in the middle of a frame.
        do_reset();
        run_frame(3, 3, 2, 2, 50, 1'b0, 1'b0);
        check("ferr_sticky", frame_err_o, 1);
        check("ferr_fill_count", g_fills, ROWS);
        check("ferr_max_row", g_max_row, ROWS - 1);
        check("ferr_end_sel", buff_sel_o, 0);

        // Reset while buffer 1 fill is pending, then a stray done.
        do_reset();
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b01);
        check("mid_fill_req", buff_fill_req_o, 2'b10);
        do_reset();
        cycle(1'b0, 1'b0, 2'b10);
        check_all_zero("stray_done");
        cycle(1'b0, 1'b1, 2'b00);
        check_all_zero("idle_line_end");
        cycle(1'b1, 1'b0, 2'b00);
        check("post_reset_idle_start", buff_fill_req_o, 2'b01);

        // Randomized frames with noise on every input.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(2, 6, 1, 10, -1, 1'b0, 1'b1);
            check($sformatf("rnd%0d_fill_count", f), g_fills, ROWS);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
